// File: rtl/pc_unit.sv
// Program counter with a LIFO return-address stack for CALL/RET; new PC is visible one cycle after the command edge.
// EN low is a full stall: PC, stack, count and ERR all hold and commands are ignored.
module pc_unit #(
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    STACK_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VEC   = '0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  EN,
   input  logic                  Z,
   input  logic                  JMP,
   input  logic                  JZ,
   input  logic                  JNZ,
   input  logic                  CALL,
   input  logic                  RET,
   input  logic [ADDR_WIDTH-1:0] TARGET,
   output logic [ADDR_WIDTH-1:0] PC,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic                  ERR
);

   localparam int IW = $clog2(STACK_DEPTH);
   localparam int CW = IW + 1;

   logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_d;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic [ADDR_WIDTH-1:0] pc_inc;
   logic [IW-1:0]         top_idx;
   logic [IW-1:0]         push_idx;
   logic                  err_d;
   logic                  push;

   // Wraps modulo 2^ADDR_WIDTH, which is also the value CALL pushes at the top address.
   assign pc_inc   = PC + ADDR_WIDTH'(1);
   assign FULL     = (cnt == CW'(STACK_DEPTH));
   assign EMPTY    = (cnt == '0);
   assign top_idx  = IW'(cnt - CW'(1));
   assign push_idx = IW'(cnt);

   // One action per cycle; a higher-priority command masks all lower ones completely.
   always_comb begin
      pc_d  = pc_inc;
      cnt_d = cnt;
      err_d = ERR;
      push  = 1'b0;
      if (RET) begin
         if (!EMPTY) begin
            pc_d  = stack[top_idx];
            cnt_d = cnt - CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (CALL) begin
         if (!FULL) begin
            push  = 1'b1;
            pc_d  = TARGET;
            cnt_d = cnt + CW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (JMP) begin
         pc_d = TARGET;
      end else if (JZ) begin
         pc_d = Z ? TARGET : pc_inc;
      end else if (JNZ) begin
         pc_d = Z ? pc_inc : TARGET;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         PC  <= RESET_VEC;
         cnt <= '0;
         ERR <= 1'b0;
      end else if (EN) begin
         PC  <= pc_d;
         cnt <= cnt_d;
         ERR <= err_d;
      end
   end

   // Entry contents need no reset; only the count defines what is valid.
   always_ff @(posedge CLK) begin
      if (!RST && EN && push) begin
         stack[push_idx] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model feeds a scoreboard of expected PC/flags per cycle.
module tb_pc_unit;

   logic       CLK;
   logic       RST, EN, Z, JMP, JZ, JNZ, CALL, RET;
   logic [7:0] TARGET;
   logic [7:0] PC;
   logic       FULL, EMPTY, ERR;

   int n_cmp = 0;
   int n_bad = 0;
   int step  = 0;

   typedef struct packed {
      logic [7:0] pc;
      logic       full;
      logic       empty;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_stk[$];
   logic [7:0] m_pc;
   logic       m_err;

   pc_unit #(.ADDR_WIDTH(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .Z(Z), .JMP(JMP), .JZ(JZ), .JNZ(JNZ),
      .CALL(CALL), .RET(RET), .TARGET(TARGET), .PC(PC), .FULL(FULL),
      .EMPTY(EMPTY), .ERR(ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic en, input logic rst, input logic ret, input logic call,
                      input logic jmp, input logic jz, input logic jnz, input logic z,
                      input logic [7:0] tgt);
      logic [7:0] inc;
      exp_t       e;
      exp_t       got;
      EN = en; RST = rst; RET = ret; CALL = call; JMP = jmp; JZ = jz; JNZ = jnz;
      Z = z; TARGET = tgt;
      inc = m_pc + 8'd1;
      if (rst) begin
         m_pc = 8'h00; m_err = 1'b0; m_stk.delete();
      end else if (en) begin
         if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = inc; m_err = 1'b1; end
         end else if (call) begin
            if (m_stk.size() < 4) begin m_stk.push_back(inc); m_pc = tgt; end
            else begin m_pc = inc; m_err = 1'b1; end
         end else if (jmp) m_pc = tgt;
         else if (jz)  m_pc = z ? tgt : inc;
         else if (jnz) m_pc = z ? inc : tgt;
         else          m_pc = inc;
      end
      e.pc = m_pc; e.full = (m_stk.size() == 4); e.empty = (m_stk.size() == 0); e.err = m_err;
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      step++;
      if (exp_q.size() == 0) begin
         chk($sformatf("step%0d_queue", step), 0, 1);
      end else begin
         got = exp_q.pop_front();
         chk($sformatf("step%0d_pc", step),    PC,    got.pc);
         chk($sformatf("step%0d_full", step),  FULL,  got.full);
         chk($sformatf("step%0d_empty", step), EMPTY, got.empty);
         chk($sformatf("step%0d_err", step),   ERR,   got.err);
      end
   endtask

   task automatic idle();               cyc(1, 0, 0, 0, 0, 0, 0, 0, 8'h00); endtask
   task automatic jmp_to(input logic [7:0] t); cyc(1, 0, 0, 0, 1, 0, 0, 0, t); endtask
   task automatic call_to(input logic [7:0] t); cyc(1, 0, 0, 1, 0, 0, 0, 0, t); endtask
   task automatic ret_op();             cyc(1, 0, 1, 0, 0, 0, 0, 0, 8'h00); endtask

   initial begin
      {RST, EN, Z, JMP, JZ, JNZ, CALL, RET} = '0;
      TARGET = 8'h00;
      m_pc = 8'h00; m_err = 1'b0;

      // reset then free-running increment
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("rst_pc", PC, 8'h00);
      chk("rst_empty", EMPTY, 1);
      chk("rst_full", FULL, 0);
      chk("rst_err", ERR, 0);
      for (int i = 1; i <= 5; i++) begin
         idle();
         chk($sformatf("idle_pc%0d", i), PC, i);
      end
      chk("idle_empty", EMPTY, 1);
      chk("idle_err", ERR, 0);

      // conditional branches
      jmp_to(8'h10);
      cyc(1, 0, 0, 0, 0, 1, 0, 1, 8'h40);
      chk("jz_taken", PC, 8'h40);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h40);
      chk("jz_not_taken", PC, 8'h41);
      cyc(1, 0, 0, 0, 0, 0, 1, 0, 8'h80);
      chk("jnz_taken", PC, 8'h80);
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 8'h80);
      chk("jnz_not_taken", PC, 8'h81);
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 8'hC0);
      chk("jz_over_jnz", PC, 8'h82);
      cyc(1, 0, 0, 0, 1, 1, 0, 0, 8'hC4);
      chk("jmp_over_jz", PC, 8'hC4);

      // nested call/return
      jmp_to(8'h05);
      call_to(8'h20);
      chk("call1_pc", PC, 8'h20);
      call_to(8'h30);
      chk("call2_pc", PC, 8'h30);
      ret_op();
      chk("ret1_pc", PC, 8'h21);
      ret_op();
      chk("ret2_pc", PC, 8'h06);
      chk("nest_empty", EMPTY, 1);
      chk("nest_err", ERR, 0);

      // overflow
      call_to(8'h50);
      call_to(8'h60);
      call_to(8'h70);
      chk("call3_full", FULL, 0);
      call_to(8'h90);
      chk("call4_full", FULL, 1);
      call_to(8'hA0);
      chk("ovf_pc", PC, 8'h91);
      chk("ovf_err", ERR, 1);
      chk("ovf_full", FULL, 1);
      ret_op();
      chk("ovf_ret_pc", PC, 8'h71);
      chk("ovf_ret_full", FULL, 0);

      // underflow, stall, wrap
      cyc(1, 1, 0, 0, 0, 0, 0, 0, 8'h00);
      chk("rst2_err", ERR, 0);
      jmp_to(8'h07);
      ret_op();
      chk("unf_pc", PC, 8'h08);
      chk("unf_err", ERR, 1);
      chk("unf_empty", EMPTY, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0, 1, 0, 0, 0, 8'h99);
         chk($sformatf("stall_pc%0d", i), PC, 8'h08);
      end
      jmp_to(8'hFF);
      idle();
      chk("wrap_pc", PC, 8'h00);
      jmp_to(8'hFF);
      call_to(8'h33);
      ret_op();
      chk("wrap_call_ret", PC, 8'h00);

      // priority collision and mid-sequence reset
      jmp_to(8'h11);
      call_to(8'h44);
      cyc(1, 0, 1, 1, 1, 0, 0, 0, 8'h77);
      chk("prio_pc", PC, 8'h12);
      chk("prio_empty", EMPTY, 1);
      call_to(8'h01);
      call_to(8'h02);
      call_to(8'h03);
      cyc(0, 0, 1, 0, 0, 0, 0, 0, 8'h00);
      chk("stall_ret_pc", PC, 8'h03);
      chk("stall_ret_empty", EMPTY, 0);
      cyc(0, 1, 0, 1, 0, 0, 0, 0, 8'h55);
      chk("rst3_pc", PC, 8'h00);
      chk("rst3_empty", EMPTY, 1);
      chk("rst3_err", ERR, 0);
      idle();
      chk("post_rst_pc", PC, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
